// File: rtl/matrix_alu_sequencer.sv
// Byte-serial front end for the 5x5 matrix ALU: loads A/B, pulses start, waits, streams the result.
// Optional OVF_ABORT_EN: drop the result stream and flag err_illegal when the ALU reports overflow.
module matrix_alu_sequencer #(
  parameter int SEQ_LATENCY  = 32,
  parameter int COMB_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [7:0]   cmd_scalar,
  input  logic         elem_valid,
  output logic         elem_ready,
  input  logic [7:0]   elem_data,
  output logic [2:0]   alu_op_code,
  output logic [199:0] alu_matrix_a,
  output logic [199:0] alu_matrix_b,
  output logic [7:0]   alu_scalar,
  output logic         alu_start,
  input  logic [199:0] alu_result,
  input  logic         alu_overflow,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [7:0]   res_data,
  output logic         res_last,
  output logic         res_overflow,
  output logic         err_illegal,
  output logic         busy
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_UNLOAD = 3'd5;

  localparam int MAXL = (SEQ_LATENCY > COMB_LATENCY) ? SEQ_LATENCY : COMB_LATENCY;
  localparam int CW   = $clog2(MAXL + 1);

  logic [2:0]    state;
  logic [4:0]    k;
  logic [CW-1:0] wcnt;
  logic [199:0]  result;

  function automatic logic needs_b(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b001) || (op == 3'b110);
  endfunction

  assign cmd_ready  = (state == S_IDLE);
  assign elem_ready = (state == S_LOAD_A) || (state == S_LOAD_B);
  assign alu_start  = (state == S_EXEC);
  assign res_valid  = (state == S_UNLOAD);
  assign res_data   = result[{k, 3'b000} +: 8];
  assign res_last   = (state == S_UNLOAD) && (k == 5'd24);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      k            <= '0;
      wcnt         <= '0;
      result       <= '0;
      alu_op_code  <= '0;
      alu_scalar   <= '0;
      alu_matrix_a <= '0;
      alu_matrix_b <= '0;
      res_overflow <= 1'b0;
      err_illegal  <= 1'b0;
    end else begin
      err_illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            alu_op_code <= cmd_op;
            alu_scalar  <= cmd_scalar;
            if (cmd_op == 3'b101 || cmd_op == 3'b111) begin
              err_illegal <= 1'b1;
            end else begin
              k     <= '0;
              state <= S_LOAD_A;
            end
          end
        end
        S_LOAD_A: begin
          if (elem_valid) begin
            alu_matrix_a[{k, 3'b000} +: 8] <= elem_data;
            if (k == 5'd24) begin
              k     <= '0;
              state <= needs_b(alu_op_code) ? S_LOAD_B : S_EXEC;
            end else begin
              k <= k + 5'd1;
            end
          end
        end
        S_LOAD_B: begin
          if (elem_valid) begin
            alu_matrix_b[{k, 3'b000} +: 8] <= elem_data;
            if (k == 5'd24) begin
              k     <= '0;
              state <= S_EXEC;
            end else begin
              k <= k + 5'd1;
            end
          end
        end
        S_EXEC: begin
          wcnt  <= (alu_op_code == 3'b110) ? CW'(SEQ_LATENCY) : CW'(COMB_LATENCY);
          state <= S_WAIT;
        end
        S_WAIT: begin
          // WAIT lasts exactly wcnt cycles; capture on the edge that takes it to zero
          if (wcnt <= CW'(1)) begin
            wcnt         <= '0;
            result       <= alu_result;
            res_overflow <= alu_overflow;
            k            <= '0;
`ifdef OVF_ABORT_EN
            if (alu_overflow) begin
              err_illegal <= 1'b1;
              state       <= S_IDLE;
            end else begin
              state <= S_UNLOAD;
            end
`else
            state <= S_UNLOAD;
`endif
          end else begin
            wcnt <= wcnt - CW'(1);
          end
        end
        S_UNLOAD: begin
          if (res_ready) begin
            if (k == 5'd24) begin
              k     <= '0;
              state <= S_IDLE;
            end else begin
              k <= k + 5'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_alu_sequencer.sv
// Directed bench for matrix_alu_sequencer with a small behavioural ALU (add, transpose, time-stamped multiply).
module tb_matrix_alu_sequencer;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = '0;
  logic [7:0]   cmd_scalar = '0;
  logic         elem_valid = 1'b0;
  logic         elem_ready;
  logic [7:0]   elem_data = '0;
  logic [2:0]   alu_op_code;
  logic [199:0] alu_matrix_a, alu_matrix_b;
  logic [7:0]   alu_scalar;
  logic         alu_start;
  logic [199:0] alu_result;
  logic         alu_overflow = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [7:0]   res_data;
  logic         res_last;
  logic         res_overflow;
  logic         err_illegal;
  logic         busy;

  int checks = 0, fails = 0;
  int n_start = 0, n_err = 0, n_rv = 0;
  logic [7:0] sc = '0;

  matrix_alu_sequencer #(.SEQ_LATENCY(32), .COMB_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_scalar(cmd_scalar),
    .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_data(elem_data),
    .alu_op_code(alu_op_code), .alu_matrix_a(alu_matrix_a), .alu_matrix_b(alu_matrix_b),
    .alu_scalar(alu_scalar), .alu_start(alu_start), .alu_result(alu_result),
    .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .res_overflow(res_overflow), .err_illegal(err_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  // sc counts edges since alu_start rose (pre-update value is seen by the DUT), so stamp = sc+1
  always @(posedge clk) begin
    if (alu_start)   n_start <= n_start + 1;
    if (err_illegal) n_err   <= n_err + 1;
    if (res_valid)   n_rv    <= n_rv + 1;
    if (alu_start) sc <= 8'd1;
    else if (sc != 8'd0) sc <= sc + 8'd1;
  end

  always_comb begin
    alu_result = alu_matrix_a;
    case (alu_op_code)
      3'b000: for (int i = 0; i < 25; i++)
                alu_result[8*i +: 8] = alu_matrix_a[8*i +: 8] + alu_matrix_b[8*i +: 8];
      3'b010: for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                  alu_result[8*(r*5+c) +: 8] = alu_matrix_a[8*(c*5+r) +: 8];
      3'b110: for (int i = 0; i < 25; i++)
                alu_result[8*i +: 8] = ((sc == 8'd0) ? 8'd0 : sc + 8'd1) + 8'(i);
      default: ;
    endcase
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] s);
    int t = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_scalar = s;
    while (!cmd_ready && t < 100) begin step; t++; end
    if (!cmd_ready) chk("cmd_ready_wait", cmd_ready, 1);
    step;
    cmd_valid = 1'b0;
  endtask

  task automatic send_mat(input logic [199:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      elem_valid = 1'b1; elem_data = m[8*i +: 8];
      while (!elem_ready && t < 100) begin step; t++; end
      if (!elem_ready) chk("elem_ready_wait", elem_ready, 1);
      step;
    end
    elem_valid = 1'b0;
  endtask

  task automatic recv(output logic [199:0] got, output logic [24:0] lastv, input int stall_at);
    got = '0; lastv = '0;
    res_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      int t = 0;
      while (!res_valid && t < 200) begin step; t++; end
      if (!res_valid) chk("res_valid_wait", res_valid, 1);
      got[8*i +: 8] = res_data;
      lastv[i] = res_last;
      if (i == stall_at) begin
        logic [7:0] d;
        d = res_data;
        res_ready = 1'b0;
        repeat (3) begin
          step;
          chk("stall_hold", {res_valid, res_data}, {1'b1, d});
        end
        res_ready = 1'b1;
      end
      step;
    end
    res_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [199:0] got, ak, tt;
    logic [24:0]  lv;
    int s0, e0, v0, cyc;

    for (int i = 0; i < 25; i++) ak[8*i +: 8] = 8'(i);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) tt[8*(r*5+c) +: 8] = 8'(c*5 + r);

    // reset state
    repeat (2) step;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_flags", {busy, elem_ready, res_valid, res_last, alu_start, err_illegal, res_overflow}, 0);
    chk("rst_regs", {alu_op_code, alu_scalar}, 0);
    chk("rst_mat_a", alu_matrix_a, 0);
    chk("rst_mat_b", alu_matrix_b, 0);
    rst = 1'b0;
    step;

    // op 000: 3 + 4 = 7 everywhere
    s0 = n_start;
    send_cmd(3'b000, 8'd0);
    send_mat({25{8'd3}}, 25);
    send_mat({25{8'd4}}, 25);
    cyc = 1;  // cycle of the last element handshake counts as 1
    while (!res_valid && cyc < 100) begin step; cyc++; end
    chk("comb_latency", cyc, 3);
    recv(got, lv, -1);
    chk("add_data", got, {25{8'd7}});
    chk("add_last", lv, 25'h1000000);
    chk("add_start_once", n_start - s0, 1);
    chk("add_ovf", res_overflow, 0);
    chk("add_idle", {busy, res_valid}, 0);

    // op 010: transpose, B untouched, no extra elements consumed
    send_cmd(3'b010, 8'd0);
    send_mat(ak, 25);
    elem_valid = 1'b1; elem_data = 8'hEE;
    chk("tr_no_elem_ready", elem_ready, 0);
    chk("tr_b_kept", alu_matrix_b, {25{8'd4}});
    recv(got, lv, -1);
    elem_valid = 1'b0;
    chk("tr_slot1", got[15:8], 8'd5);
    chk("tr_slot5", got[47:40], 8'd1);
    chk("tr_data", got, tt);
    chk("tr_a_kept", alu_matrix_a, ak);

    // op 110: sampled 33 edges after alu_start, 3-cycle output stall mid-stream
    s0 = n_start;
    send_cmd(3'b110, 8'd0);
    send_mat(ak, 25);
    send_mat({25{8'd1}}, 25);
    recv(got, lv, 10);
    for (int i = 0; i < 25; i++) tt[8*i +: 8] = 8'(33 + i);
    chk("mul_stamp_elem0", got[7:0], 8'd33);
    chk("mul_data", got, tt);
    chk("mul_last", lv, 25'h1000000);
    chk("mul_start_once", n_start - s0, 1);

    // illegal ops
    e0 = n_err;
    send_cmd(3'b111, 8'd0);
    chk("ill111_pulse", err_illegal, 1);
    chk("ill111_state", {busy, elem_ready, cmd_ready}, 3'b001);
    step;
    chk("ill111_one_cycle", err_illegal, 0);
    chk("ill111_count", n_err - e0, 1);
    send_cmd(3'b101, 8'h55);
    chk("ill101_pulse", {err_illegal, busy}, 2'b10);
    chk("ill101_scalar", alu_scalar, 8'h55);
    step;

    // overflow: 100 + 100 wraps to 0xC8 with alu_overflow set
    alu_overflow = 1'b1;
    send_cmd(3'b000, 8'd0);
    send_mat({25{8'd100}}, 25);
    send_mat({25{8'd100}}, 25);
    v0 = n_rv; e0 = n_err;
`ifdef OVF_ABORT_EN
    cyc = 0;
    while (busy && cyc < 100) begin step; cyc++; end
    step;
    chk("ovf_abort_idle", busy, 0);
    chk("ovf_abort_no_res", n_rv - v0, 0);
    chk("ovf_abort_err", n_err - e0, 1);
`else
    recv(got, lv, -1);
    chk("ovf_data", got, {25{8'hC8}});
    chk("ovf_count", n_rv - v0, 25);
    chk("ovf_last", lv, 25'h1000000);
`endif
    alu_overflow = 1'b0;
    chk("ovf_flag", res_overflow, 1);

    // reset in LOAD_B after 10 elements, then a fresh command starts at k=0
    send_cmd(3'b000, 8'd0);
    send_mat(ak, 25);
    send_mat({25{8'd9}}, 10);
    rst = 1'b1;
    step;
    chk("mid_rst_state", {busy, cmd_ready, elem_ready}, 3'b010);
    chk("mid_rst_a", alu_matrix_a, 0);
    chk("mid_rst_ovf", res_overflow, 0);
    rst = 1'b0;
    s0 = n_start; v0 = n_rv;
    repeat (40) step;
    chk("mid_rst_quiet", {n_start - s0, n_rv - v0}, 0);
    send_cmd(3'b010, 8'd0);
    send_mat(ak, 25);
    recv(got, lv, -1);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) tt[8*(r*5+c) +: 8] = 8'(c*5 + r);
    chk("post_rst_tr", got, tt);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/matrix_alu_sequencer.md
Name: matrix_alu_sequencer

Overview:
- Initiator that drives the 5x5 matrix ALU's operand/opcode/start interface from a byte-serial host side.
- Collects matrix A, and matrix B when the operation needs it, as 8-bit signed elements.
- Issues the operation, waits the ALU's latency, then captures the 200-bit result and streams it back out element by element.
- Sits between the host/UART command path and the matrix ALU.

Parameters:
- SEQ_LATENCY, 32: cycles to wait after alu_start before sampling the result for op 3'b110 (matrix multiply); must be >= 2.
- COMB_LATENCY, 1: cycles to wait before sampling for combinational ops (000–100); must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command (IDLE only)
- cmd_op  in  3  ALU op code
- cmd_scalar  in  8  signed scalar for op 100
- elem_valid  in  1  operand element offered
- elem_ready  out  1  operand element accepted this cycle when elem_valid=1
- elem_data  in  8  signed operand element, row-major
- alu_op_code  out  3  to ALU op_code
- alu_matrix_a  out  200  to ALU matrix_a
- alu_matrix_b  out  200  to ALU matrix_b
- alu_scalar  out  8  to ALU scalar
- alu_start  out  1  one-cycle start pulse to ALU
- alu_result  in  200  from ALU result_final
- alu_overflow  in  1  from ALU overflow
- res_valid  out  1  result element valid
- res_ready  in  1  host accepts result element
- res_data  out  8  result element
- res_last  out  1  high with element 24
- res_overflow  out  1  overflow of the last completed operation
- err_illegal  out  1  one-cycle pulse: illegal op rejected
- busy  out  1  high in any state other than IDLE

Behaviour:
- Packing: element k = row*5+col occupies bits [8k+7:8k] of all 200-bit buses; element 0 is streamed first.
- Reset (sync, rst=1 at a clk edge) forces:
  - state IDLE; cmd_ready=1.
  - alu_start, res_valid, res_last, err_illegal, busy, elem_ready = 0.
  - res_overflow=0.
  - alu_matrix_a, alu_matrix_b, alu_op_code, alu_scalar = 0; all counters 0.
  - Reset mid-operation abandons the operation; no further alu_start or res_valid.
- Handshakes: a transfer occurs on a clk edge with valid&ready both high. res_data/res_last are held stable while res_valid=1 and res_ready=0.
- IDLE: on a cmd handshake, latch cmd_op into alu_op_code and cmd_scalar into alu_scalar.
  - Op 3'b101 and 3'b111: pulse err_illegal the next cycle; stay in IDLE; other state unchanged.
  - Otherwise: clear the element counter and go to LOAD_A.
- LOAD_A: elem_ready=1. Each accepted element writes slot k of alu_matrix_a, then k increments. After the element with k=24:
  - op 000, 001 or 110: go to LOAD_B.
  - otherwise: go to EXEC.
- LOAD_B: same as LOAD_A but writes alu_matrix_b; after k=24 go to EXEC. For ops skipping B, alu_matrix_b keeps its previous value.
- EXEC: alu_start=1 for exactly this one cycle. Load the wait counter with SEQ_LATENCY for op 110, else COMB_LATENCY. Go to WAIT.
- WAIT: decrement the counter each cycle; operands are held constant. When the counter reaches 0, capture alu_result into the result register and alu_overflow into res_overflow, then go to UNLOAD.
- UNLOAD: res_valid=1 and res_data = result slot k, with k starting at 0.
  - Each res handshake increments k.
  - The handshake on k=24 (res_last=1) returns to IDLE, with res_valid=0 the following cycle.
- Latency for a combinational op: last B (or A) element handshake -> EXEC (1 cycle) -> WAIT (COMB_LATENCY cycles) -> first res_valid. With COMB_LATENCY=1 that is 3 cycles.
- cmd_valid outside IDLE is ignored (cmd_ready=0). elem_valid outside the LOAD states is not accepted.
- res_overflow holds its value until the next capture or reset.

Optional Feature:
- Macro OVF_ABORT_EN.
- Defined: if the captured alu_overflow=1, skip UNLOAD and return directly to IDLE. res_overflow=1 and err_illegal also pulses for one cycle; no result elements are emitted.
- Undefined: result is always streamed regardless of overflow; only res_overflow reports it.

Test Plan:
- Reset during LOAD_B after 10 B elements -> next cycle busy=0, cmd_ready=1, elem_ready=0, alu_matrix_a=0; a new command loads from k=0.
- Op 000: A all 8'd3, B all 8'd4 -> exactly one alu_start pulse; 25 res_data=8'd7 with res_last only on the 25th; res_overflow=0; busy low after.
- Op 010: A element k = k -> only 25 elements are consumed and elem_ready=0 afterwards; alu_matrix_b is unchanged; streamed result is the transpose (output slot 1 = 5, slot 5 = 1).
- Op 110 with SEQ_LATENCY=32 -> result sampled exactly 33 cycles after alu_start.
- Op 110 output stalls: res_ready toggles low for 3 cycles mid-stream -> res_data is held stable and no element is lost.
- Op 111 -> err_illegal pulses once, no elem_ready.
- Op 000: A all 8'd100, B all 8'd100 with ALU overflow=1 -> res_overflow=1.
  - Without OVF_ABORT_EN: 25 elements are streamed.
  - With OVF_ABORT_EN: zero res_valid cycles and one err_illegal pulse.
